// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared VGA timing constants (640x480@60), derived totals, active-window
// bounds and the receive-side lock state encoding. Used by the timing
// generator and by vga_rx_decoder / vga_axis_tracker.
package vga_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counters start at the sync assertion, so the visible area follows
  // the sync pulse and back porch.
  localparam int H_ACT_LO = H_SYNC + H_BP;
  localparam int H_ACT_HI = H_ACT_LO + H_ACTIVE - 1;
  localparam int V_ACT_LO = V_SYNC + V_BP;
  localparam int V_ACT_HI = V_ACT_LO + V_ACTIVE - 1;

  localparam logic [9:0] CNT_SAT = 10'd1023;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } lock_state_t;

endpackage

// File: rtl/vga_axis_tracker.sv
// vga_axis_tracker
// One timing axis of the VGA receiver: sync falling-edge detect, saturating
// position counter, length check and active-window compare.
// Ports:
//   clk, rst      clock, async active-high reset
//   pix_en        sample enable; nothing changes without it
//   sync          active-low sync input for this axis (clears the counter)
//   step          count enable (1 for pixels, Hsync assertion for lines)
//   fall          sync assertion seen on this sample
//   cnt_nxt       counter value that this sample will leave behind
//   len_ok        count at the moment of assertion equals TOTAL-1
//   sat_hit       counter is about to reach saturation on this sample
//   active        cnt_nxt lies inside [WIN_LO, WIN_HI]
module vga_axis_tracker
  import vga_timing_pkg::*;
#(
  parameter int TOTAL  = 800,
  parameter int WIN_LO = 144,
  parameter int WIN_HI = 783
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  input  logic       sync,
  input  logic       step,
  output logic       fall,
  output logic [9:0] cnt_nxt,
  output logic       len_ok,
  output logic       sat_hit,
  output logic       active
);

  logic       sync_prev;
  logic [9:0] cnt;

  assign fall = pix_en & sync_prev & ~sync;

  always_comb begin
    cnt_nxt = cnt;
    if (fall)
      cnt_nxt = '0;
    else if (pix_en && step && cnt != CNT_SAT)
      cnt_nxt = cnt + 10'd1;
  end

  // Saturation is reported once, on the step that lands on 1023; a counter
  // already parked there (e.g. straight after reset) stays quiet.
  assign sat_hit = ~fall & pix_en & step & (cnt == CNT_SAT - 10'd1);
  assign len_ok  = (cnt == 10'(TOTAL - 1));
  assign active  = (cnt_nxt >= 10'(WIN_LO)) && (cnt_nxt <= 10'(WIN_HI));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_prev <= 1'b1;
      cnt       <= CNT_SAT;
    end else if (pix_en) begin
      sync_prev <= sync;
      cnt       <= cnt_nxt;
    end
  end

endmodule

// File: rtl/vga_rx_decoder.sv
// vga_rx_decoder
// Receive-side VGA timing decoder: recovers pixel coordinates, active-video
// qualification, lock status and a per-frame checksum from Hsync/Vsync/screen.
// Ports:
//   clk, reset    clock, async active-high reset
//   pix_en        pixel-rate enable
//   Hsync, Vsync  active-low syncs
//   screen        RGB444 pixel colour
//   rx_x, rx_y    coordinates of the registered pixel (0 outside active area)
//   rx_valid      rx_x/rx_y/rx_pixel describe an active pixel
//   rx_pixel      registered copy of screen
//   frame_start   one-cycle pulse per Vsync assertion
//   locked        timing matches the parameters
//   sync_err      one-cycle pulse on a length/saturation failure while locked
//   frame_sum     16-bit sum of the last complete locked frame
//
// state  | meaning
// SEARCH | waiting for a Vsync assertion to start measuring
// ALIGN  | measuring one frame; every line and the frame length must match
// LOCKED | timing confirmed; any mismatch raises sync_err and drops lock
module vga_rx_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        Hsync,
  input  logic        Vsync,
  input  logic [11:0] screen,
  output logic [9:0]  rx_x,
  output logic [9:0]  rx_y,
  output logic        rx_valid,
  output logic [11:0] rx_pixel,
  output logic        frame_start,
  output logic        locked,
  output logic        sync_err,
  output logic [15:0] frame_sum
);

  localparam int H_LEN    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_LEN    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_WIN_LO = H_SYNC + H_BP;
  localparam int V_WIN_LO = V_SYNC + V_BP;

  logic       h_fall, h_len_ok, h_sat, h_act;
  logic       v_fall, v_len_ok, v_sat, v_act;
  logic [9:0] h_cnt_nxt, v_cnt_nxt;
  logic       pix_act, fail;
  logic [15:0] acc;

  lock_state_t state, state_nxt;

  vga_axis_tracker #(
    .TOTAL (H_LEN),
    .WIN_LO(H_WIN_LO),
    .WIN_HI(H_WIN_LO + H_ACTIVE - 1)
  ) u_h (
    .clk    (clk),
    .rst    (reset),
    .pix_en (pix_en),
    .sync   (Hsync),
    .step   (1'b1),
    .fall   (h_fall),
    .cnt_nxt(h_cnt_nxt),
    .len_ok (h_len_ok),
    .sat_hit(h_sat),
    .active (h_act)
  );

  // Lines advance on Hsync assertion; a coincident Vsync clear wins inside
  // the tracker, and the frame check sees the count before this sample.
  vga_axis_tracker #(
    .TOTAL (V_LEN),
    .WIN_LO(V_WIN_LO),
    .WIN_HI(V_WIN_LO + V_ACTIVE - 1)
  ) u_v (
    .clk    (clk),
    .rst    (reset),
    .pix_en (pix_en),
    .sync   (Vsync),
    .step   (h_fall),
    .fall   (v_fall),
    .cnt_nxt(v_cnt_nxt),
    .len_ok (v_len_ok),
    .sat_hit(v_sat),
    .active (v_act)
  );

  assign pix_act = pix_en & h_act & v_act;
  assign fail    = (h_fall & ~h_len_ok) | (v_fall & ~v_len_ok) | h_sat | v_sat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SEARCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SEARCH:  if (v_fall) state_nxt = ALIGN;
      ALIGN:   if (fail) state_nxt = SEARCH;
               else if (v_fall) state_nxt = LOCKED;
      LOCKED:  if (fail) state_nxt = SEARCH;
      default: state_nxt = SEARCH;
    endcase
  end

  assign locked = (state == LOCKED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_x        <= '0;
      rx_y        <= '0;
      rx_valid    <= 1'b0;
      rx_pixel    <= '0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
      frame_sum   <= '0;
      acc         <= '0;
    end else begin
      // Both pulse sources are already gated by pix_en, so they self-clear.
      frame_start <= v_fall;
      sync_err    <= fail & (state == LOCKED);
      if (pix_en) begin
        rx_valid <= pix_act;
        rx_pixel <= screen;
        rx_x     <= pix_act ? h_cnt_nxt - 10'(H_WIN_LO) : '0;
        rx_y     <= pix_act ? v_cnt_nxt - 10'(V_WIN_LO) : '0;
        if (v_fall) begin
          if (state == LOCKED || state_nxt == LOCKED)
            frame_sum <= acc;
          acc <= pix_act ? 16'(screen) : '0;
        end else if (pix_act) begin
          acc <= acc + 16'(screen);
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_rx_decoder.sv
module tb_vga_rx_decoder;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 6, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;   // 15
  localparam int VT = VA + VF + VS + VB;   // 11
  localparam int HOFF = HS + HB;           // 5
  localparam int VOFF = VS + VB;           // 4

  logic        clk = 1'b0;
  logic        reset, pix_en, Hsync, Vsync;
  logic [11:0] screen;
  logic [9:0]  rx_x, rx_y;
  logic        rx_valid, frame_start, locked, sync_err;
  logic [11:0] rx_pixel;
  logic [15:0] frame_sum;

  vga_rx_decoder #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .Hsync(Hsync), .Vsync(Vsync),
    .screen(screen), .rx_x(rx_x), .rx_y(rx_y), .rx_valid(rx_valid),
    .rx_pixel(rx_pixel), .frame_start(frame_start), .locked(locked),
    .sync_err(sync_err), .frame_sum(frame_sum)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  bit run_chk = 0;
  int err_cnt = 0, val_cnt = 0;

  // model state (spec-level quantities)
  int  m_hc, m_vc, m_lk, m_acc;
  bit  m_hp, m_vp;
  int  m_x, m_y, m_pix, m_sum;
  bit  m_valid, m_fs, m_err, m_locked;
  // expectations visible after the latest edge
  int  e_x, e_y, e_pix, e_sum;
  bit  e_valid, e_fs, e_err, e_locked;

  // snapshots taken inside frames
  int s_lock, s_sum, s_fs, s_x0, s_y0, s_v0, s_x1, s_y1, s_v1, s_v2;

  task automatic chk(input string name, input int got, input int expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, got, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_hc = 1023; m_vc = 1023; m_hp = 1; m_vp = 1; m_lk = 0; m_acc = 0;
    m_x = 0; m_y = 0; m_pix = 0; m_sum = 0;
    m_valid = 0; m_fs = 0; m_err = 0; m_locked = 0;
    e_x = 0; e_y = 0; e_pix = 0; e_sum = 0;
    e_valid = 0; e_fs = 0; e_err = 0; e_locked = 0;
  endtask

  task automatic model_step(input bit hs, input bit vs, input logic [11:0] scr);
    bit hfall, vfall, broken, act;
    int nh, nv, nlk;
    hfall = m_hp && !hs;
    vfall = m_vp && !vs;
    m_hp = hs; m_vp = vs;
    broken = (hfall && m_hc != HT - 1) || (vfall && m_vc != VT - 1);
    nh = hfall ? 0 : (m_hc < 1023 ? m_hc + 1 : 1023);
    nv = vfall ? 0 : ((hfall && m_vc < 1023) ? m_vc + 1 : m_vc);
    if ((nh == 1023 && m_hc != 1023) || (nv == 1023 && m_vc != 1023)) broken = 1;
    act = nh >= HOFF && nh < HOFF + HA && nv >= VOFF && nv < VOFF + VA;
    if (m_lk == 0)      nlk = vfall ? 1 : 0;
    else if (m_lk == 1) nlk = broken ? 0 : (vfall ? 2 : 1);
    else                nlk = broken ? 0 : 2;
    m_valid = act;
    m_x = act ? nh - HOFF : 0;
    m_y = act ? nv - VOFF : 0;
    m_pix = scr;
    m_fs = vfall;
    m_err = broken && m_lk == 2;
    if (vfall) begin
      if (m_lk == 2 || nlk == 2) m_sum = m_acc;
      m_acc = act ? int'(scr) : 0;
    end else if (act) begin
      m_acc = (m_acc + int'(scr)) % 65536;
    end
    m_lk = nlk;
    m_locked = (nlk == 2);
    m_hc = nh; m_vc = nv;
  endtask

  task automatic tick();
    @(posedge clk);
    e_x = m_x; e_y = m_y; e_pix = m_pix; e_sum = m_sum;
    e_valid = m_valid; e_fs = m_fs; e_err = m_err; e_locked = m_locked;
    #1;
    err_cnt += int'(sync_err);
    val_cnt += int'(rx_valid);
  endtask

  task automatic idle_tick();
    pix_en = 1'b0;
    m_fs = 0; m_err = 0;
    tick();
  endtask

  task automatic smp(input bit hs, input bit vs, input logic [11:0] scr, input int idle);
    for (int i = 0; i < idle; i++) idle_tick();
    pix_en = 1'b1; Hsync = hs; Vsync = vs; screen = scr;
    model_step(hs, vs, scr);
    tick();
  endtask

  function automatic logic [11:0] pix_val(input int mode, input int x, input int y);
    if (mode == 0) return 12'h00F;
    return 12'(x * 37 + y * 101 + 5);
  endfunction

  // Lines vf..vl, starting at column hf of the first line and stopping after
  // column hl of the last; line sl (if any) is one pixel short.
  task automatic send_frame(input int vf, input int hf, input int vl, input int hl,
                            input int sl, input int idle, input int mode);
    for (int v = vf; v <= vl; v++) begin
      int hmax;
      hmax = (v == sl) ? HT - 2 : HT - 1;
      for (int h = (v == vf) ? hf : 0; h <= hmax; h++) begin
        logic [11:0] scr;
        if (v == vl && h > hl) break;
        if (h >= HOFF && h < HOFF + HA && v >= VOFF && v < VOFF + VA)
          scr = pix_val(mode, h - HOFF, v - VOFF);
        else
          scr = 12'hFFF;
        smp(h >= HS, v >= VS, scr, idle);
        if (v == 0 && h == 0) begin s_lock = locked; s_sum = frame_sum; s_fs = frame_start; end
        if (v == VOFF && h == HOFF) begin s_x0 = rx_x; s_y0 = rx_y; s_v0 = rx_valid; end
        if (v == VOFF + VA - 1 && h == HOFF + HA - 1) begin s_x1 = rx_x; s_y1 = rx_y; s_v1 = rx_valid; end
        if (v == VOFF + VA - 1 && h == HOFF + HA) s_v2 = rx_valid;
      end
    end
  endtask

  task automatic full_frame(input int idle, input int mode);
    send_frame(0, 0, VT - 1, HT - 1, -1, idle, mode);
  endtask

  always @(negedge clk) begin
    if (run_chk && !reset) begin
      chk("rx_x", int'(rx_x), e_x);
      chk("rx_y", int'(rx_y), e_y);
      chk("rx_valid", int'(rx_valid), int'(e_valid));
      chk("rx_pixel", int'(rx_pixel), e_pix);
      chk("frame_start", int'(frame_start), int'(e_fs));
      chk("locked", int'(locked), int'(e_locked));
      chk("sync_err", int'(sync_err), int'(e_err));
      chk("frame_sum", int'(frame_sum), e_sum);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; pix_en = 1'b0; Hsync = 1'b1; Vsync = 1'b1; screen = '0;
    model_reset();
    tick(); tick();
    chk("rst_valid", int'(rx_valid), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_sum", int'(frame_sum), 0);
    chk("rst_xy", int'({rx_x, rx_y}), 0);
    reset = 1'b0;
    run_chk = 1;

    // clean frames, constant colour, white blanking
    full_frame(0, 0);
    chk("f1_fs", s_fs, 1);
    chk("f1_lock_start", s_lock, 0);
    chk("f1_lock_end", int'(locked), 0);
    full_frame(0, 0);
    chk("f2_locked", s_lock, 1);
    chk("f2_sum", s_sum, 16'h02D0);
    chk("win_first_x", s_x0, 0);
    chk("win_first_y", s_y0, 0);
    chk("win_first_v", s_v0, 1);
    chk("win_last_x", s_x1, HA - 1);
    chk("win_last_y", s_y1, VA - 1);
    chk("win_last_v", s_v1, 1);
    chk("win_past_v", s_v2, 0);
    full_frame(0, 0);
    chk("f3_sum", s_sum, 16'h02D0);

    // one short line while locked
    err_cnt = 0;
    send_frame(0, 0, VT - 1, HT - 1, 3, 0, 0);
    chk("short_err", err_cnt, 1);
    chk("short_unlocked", int'(locked), 0);
    err_cnt = 0;
    full_frame(0, 0);
    chk("short_a_lock", s_lock, 0);
    full_frame(0, 1);
    chk("short_relock", s_lock, 1);
    chk("short_relock_sum", s_sum, 16'h02D0);
    chk("short_no_err", err_cnt, 0);

    // Hsync stuck high after line 4
    send_frame(0, 0, 4, HT - 1, -1, 0, 1);
    err_cnt = 0; val_cnt = 0;
    for (int i = 0; i < 1100; i++) smp(1'b1, 1'b1, 12'hFFF, 0);
    chk("stuck_err", err_cnt, 1);
    chk("stuck_valid", val_cnt, 0);
    chk("stuck_unlocked", int'(locked), 0);
    full_frame(0, 1);
    full_frame(0, 1);
    chk("stuck_relock", s_lock, 1);

    // pix_en at 1:3 duty
    full_frame(3, 0);
    full_frame(3, 0);
    chk("duty_sum", s_sum, 16'h02D0);
    chk("duty_locked", s_lock, 1);
    chk("duty_last_x", s_x1, HA - 1);
    chk("duty_last_y", s_y1, VA - 1);

    // reset mid-frame on an active pixel
    send_frame(0, 0, 6, 8, -1, 0, 0);
    chk("pre_rst_valid", int'(rx_valid), 1);
    chk("pre_rst_locked", int'(locked), 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", int'(rx_valid), 0);
    chk("mid_rst_locked", int'(locked), 0);
    chk("mid_rst_sum", int'(frame_sum), 0);
    chk("mid_rst_x", int'(rx_x), 0);
    chk("mid_rst_y", int'(rx_y), 0);
    chk("mid_rst_pix", int'(rx_pixel), 0);
    model_reset();
    idle_tick(); idle_tick();
    reset = 1'b0;
    err_cnt = 0;
    send_frame(6, 9, VT - 1, HT - 1, -1, 0, 0);
    full_frame(0, 0);
    chk("rst_align_locked", int'(locked), 0);
    full_frame(0, 0);
    chk("rst_relock", s_lock, 1);
    chk("rst_relock_sum", s_sum, 16'h02D0);
    chk("rst_no_err", err_cnt, 0);

    run_chk = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_rx_decoder.md
# vga_rx_decoder

Receive-side counterpart of the VGA timing generator. Samples Hsync, Vsync and the 12-bit screen colour bus at pixel rate and recovers pixel coordinates, active-video qualification, sync lock status and a per-frame pixel checksum. Sits on the loopback path of the Pong top level, where it self-checks rendered frames in simulation and on hardware (ILA/LED debug).

## Interface
Parameters (640x480@60 defaults):
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, Hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, Vsync pulse width
- V_BP, 33, vertical back porch

Ports:
- clk  in  1  system clock; one clock for the whole block
- reset  in  1  asynchronous, active-high
- pix_en  in  1  pixel-rate enable; all sampling and counting occurs only on clk edges with pix_en=1
- Hsync  in  1  horizontal sync, active-low
- Vsync  in  1  vertical sync, active-low
- screen  in  12  RGB444 pixel colour
- rx_x  out  10  recovered x, 0..H_ACTIVE-1
- rx_y  out  10  recovered y, 0..V_ACTIVE-1
- rx_valid  out  1  rx_x/rx_y/rx_pixel describe an active pixel
- rx_pixel  out  12  registered copy of screen
- frame_start  out  1  one-cycle pulse on each Vsync assertion
- locked  out  1  timing matches parameters
- sync_err  out  1  one-cycle pulse on a line- or frame-length mismatch while locked
- frame_sum  out  16  sum mod 2^16 of all active pixels of the last complete frame

## Operation
- Derived: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- Sync assertion = sampled 1 -> 0 transition (previous-sample register, updated on pix_en).
- hcnt (10b): cleared to 0 on Hsync assertion, else +1, saturating at 1023. vcnt (10b): cleared on Vsync assertion, else +1 on each Hsync assertion, saturating at 1023.
- Simultaneous Hsync and Vsync assertion: both counters cleared in the same cycle.
- Active: hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] and vcnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1]; rx_x = hcnt-(H_SYNC+H_BP), rx_y = vcnt-(V_SYNC+V_BP).
- Line check at Hsync assertion: hcnt must equal H_TOTAL-1. Frame check at Vsync assertion: vcnt must equal V_TOTAL-1 (Hsync assertion coincident with Vsync counted first). Counter saturation counts as a failure.
- Lock FSM:
  - SEARCH: wait for Vsync assertion -> ALIGN.
  - ALIGN: every line check passes until next Vsync assertion and frame check passes -> LOCKED; any failure -> SEARCH (no sync_err).
  - LOCKED: locked=1; any failure -> sync_err pulse, -> SEARCH.
- Checksum: accumulator adds screen on every active sample; at Vsync assertion, frame_sum <= accumulator if the FSM is LOCKED or entering LOCKED, accumulator cleared regardless.
- frame_start pulses on every Vsync assertion in any state.

## Timing
- Reset values: rx_x=0, rx_y=0, rx_valid=0, rx_pixel=0, frame_start=0, locked=0, sync_err=0, frame_sum=0; counters saturated (1023), FSM SEARCH, previous-sync registers 1.
- Latency: one pix_en sample; outputs registered, updated on the clk edge that samples the input. Output valid from that edge until the next pix_en edge.
- locked rises on the edge sampling the second Vsync assertion after reset (first clean frame).
- sync_err, frame_start: high exactly one clk cycle, even if pix_en is continuously high.
- pix_en=0: all state and outputs hold; pulses cleared.
- Reset mid-frame: immediate return to reset values; no sync_err on the following partial frame.

## Structure
- Package vga_timing_pkg: the eight timing constants, derived H_TOTAL/V_TOTAL, active-window bounds, lock-state enum (SEARCH, ALIGN, LOCKED); shared with the timing generator.
- One sub-module, vga_axis_tracker, instantiated twice (horizontal, vertical): edge detect, saturating counter, length check, active-window compare. Top holds FSM, checksum, output registers.

## Test plan
- Clean 640x480 frames, pix_en always 1: locked=1 after 2nd Vsync assertion; sample at hcnt=144, vcnt=35 -> rx_x=0, rx_y=0, rx_valid=1; hcnt=783, vcnt=514 -> rx_x=639, rx_y=479.
- Constant screen=12'h00F over active area: frame_sum=16'h5000 after each locked frame; blanking-interval data 12'hFFF does not change it.
- Locked, then one line of 799 pixels: single sync_err pulse at that Hsync, locked=0, relock after next full clean frame.
- Hsync stuck high for 1100 samples: hcnt saturates, locked drops, sync_err once; no rx_valid.
- pix_en toggling 1:3 duty: same rx_x/rx_y sequence and frame_sum as continuous case.
- reset asserted at line 200 while locked: outputs at reset values same cycle; released -> SEARCH, relock after one clean frame, no sync_err.
